multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for a multicycle RV32 subset datapath.
//
// Sequences FETCH/DECODE and the per-class execute states. It drives the
// datapath strobes and mux selects, which are decoded from the current state
// plus the instruction register. Unsupported opcodes park the FSM in TRAP
// until the next reset.
//
// Optional feature macro: CTRL_PERF_CNT_EN adds the CycleCnt/InstretCnt
// performance counter ports.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   instr[31:0]          instruction register contents
//   EQ                   ALU equal/zero flag, used in BRANCH
//   MemReady             memory handshake acknowledge
//   PCWrite, IRWrite, RegWrite, MemReq, MemWrite   datapath strobes
//   AdrSrc               memory address select (0 PC, 1 ALU result)
//   ALUsrcA/ALUsrcB/ResultSrc/ImmSrc/ALUctrl       datapath mux selects
//   Illegal              unsupported opcode seen (held in TRAP)
//   State[3:0]           current FSM state
//   CycleCnt, InstretCnt performance counters (CTRL_PERF_CNT_EN only)
module multicycle_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        EQ,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemReq,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUsrcA,
    output logic [1:0]  ALUsrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSrc,
    output logic [2:0]  ALUctrl,
    output logic        Illegal,
    output logic [3:0]  State
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [DATA_WIDTH-1:0] CycleCnt,
    output logic [DATA_WIDTH-1:0] InstretCnt
`endif
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] LUI      = 4'd11;
    localparam logic [3:0] TRAP     = 4'd12;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b100;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [2:0] exec_alu;
    logic       taken;
    logic       unused_instr;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7_5 = instr[30];
    assign State    = state;

    // Register fields the controller never looks at (register numbers, most of
    // funct7, immediate bits) are folded together so they read as used.
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    // Only beq and bne are supported; other branch funct3 values fall through.
    assign taken = ((funct3 == 3'b000) && EQ) || ((funct3 == 3'b001) && !EQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:    if (MemReady) next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_R:              next_state = EXECR;
                    OP_I:              next_state = EXECI;
                    OP_BR:             next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    OP_LUI:            next_state = LUI;
                    default:           next_state = TRAP;
                endcase
            end
            MEMADR:   next_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (MemReady) next_state = MEMWB;
            MEMWRITE: if (MemReady) next_state = FETCH;
            MEMWB:    next_state = FETCH;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BRANCH:   next_state = FETCH;
            JAL:      next_state = ALUWB;
            LUI:      next_state = ALUWB;
            TRAP:     next_state = TRAP;
            default:  next_state = FETCH;
        endcase
    end

    // funct3 -> ALU operation; bit 30 selects sub only for register-register
    // ops, since for immediates that bit belongs to the immediate.
    always_comb begin
        exec_alu = ALU_ADD;
        case (funct3)
            3'b000:  exec_alu = ((state == EXECR) && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  exec_alu = ALU_AND;
            3'b110:  exec_alu = ALU_OR;
            3'b100:  exec_alu = ALU_XOR;
            3'b010:  exec_alu = ALU_SLT;
            3'b001:  exec_alu = ALU_SLL;
            3'b101:  exec_alu = ALU_SRL;
            default: exec_alu = ALU_ADD;
        endcase
    end

    // Output decode is gated by rst_n so strobes fall the moment reset is
    // asserted, even though FETCH itself would otherwise request memory.
    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ALUsrcA   = 2'b00;
        ALUsrcB   = 2'b00;
        ResultSrc = 2'b00;
        ImmSrc    = IMM_I;
        ALUctrl   = ALU_ADD;
        Illegal   = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    MemReq  = 1'b1;
                    ALUsrcB = 2'b10;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                DECODE: begin
                    ALUsrcA = 2'b01;
                    ALUsrcB = 2'b01;
                    ImmSrc  = IMM_B;
                end
                MEMADR: begin
                    ALUsrcA = 2'b10;
                    ALUsrcB = 2'b01;
                    ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                MEMREAD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                end
                MEMWRITE: begin
                    MemReq   = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                end
                MEMWB: begin
                    RegWrite  = 1'b1;
                    ResultSrc = 2'b01;
                end
                EXECR: begin
                    ALUsrcA = 2'b10;
                    ALUctrl = exec_alu;
                end
                EXECI: begin
                    ALUsrcA = 2'b10;
                    ALUsrcB = 2'b01;
                    ALUctrl = exec_alu;
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                end
                BRANCH: begin
                    ALUsrcA = 2'b10;
                    ALUctrl = ALU_SUB;
                    PCWrite = taken;
                end
                JAL: begin
                    PCWrite = 1'b1;
                    ALUsrcA = 2'b01;
                    ALUsrcB = 2'b10;
                end
                LUI: begin
                    ALUsrcA = 2'b10;
                    ALUsrcB = 2'b01;
                    ImmSrc  = IMM_U;
                end
                TRAP: begin
                    Illegal = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    localparam logic [DATA_WIDTH-1:0] CNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    // An instruction retires on the clock that brings the FSM back to FETCH;
    // FETCH waiting on memory and a parked TRAP never count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CycleCnt   <= '0;
            InstretCnt <= '0;
        end else begin
            CycleCnt <= CycleCnt + CNT_ONE;
            if ((state != FETCH) && (state != TRAP) && (next_state == FETCH)) begin
                InstretCnt <= InstretCnt + CNT_ONE;
            end
        end
    end
`else
    localparam int unused_data_width = DATA_WIDTH;
`endif

endmodule
